blautobr_gen2: RTL

Parametrised per-frame automatic exposure/gain controller for the camera pipeline. Counts bright-pixel flags inside a programmable measurement window during the active frame, then performs one evaluate/apply cycle at the start of vertical blanking. Exposure and gain move in single steps or proportional steps within fixed limits, with independent external overrides. It sits between the pixel-flag detector and the sensor register writer, and publishes the per-frame brightness metric and an update strobe.

---
 rtl/blautobr_gen2.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/blautobr_gen2.sv
// blautobr_gen2: windowed bright-pixel metering with one exposure/gain update per frame
module blautobr_gen2 #(
    parameter int NPIX     = 5,
    parameter int HW       = 11,
    parameter int VW       = 11,
    parameter int ACCW     = 17,
    parameter int SHIFT    = 12,
    parameter int MW       = ACCW - SHIFT,
    parameter int GW       = 8,
    parameter int GAIN_MAX = 255,
    parameter int EW       = 11,
    parameter int EXP_MIN  = 1,
    parameter int EXP_MAX  = 1027,
    parameter int STEP_MAX = 16
) (
    input  logic            i_clk,
    input  logic            i_init_n,
    input  logic            i_en,
    input  logic            i_vblank,
    input  logic [NPIX-1:0] i_pix_hit,
    input  logic [HW-1:0]   i_ah,
    input  logic [VW-1:0]   i_av,
    input  logic [HW-1:0]   i_win_h0,
    input  logic [HW-1:0]   i_win_h1,
    input  logic [VW-1:0]   i_win_v0,
    input  logic [VW-1:0]   i_win_v1,
    input  logic [MW-1:0]   i_lo_th,
    input  logic [MW-1:0]   i_hi_th,
    input  logic            i_mode_prop,
    input  logic            i_ext_gain,
    input  logic            i_ext_exp,
    input  logic [GW-1:0]   i_igain,
    input  logic [EW-1:0]   i_iexp,
    output logic [GW-1:0]   o_gain,
    output logic [EW-1:0]   o_exp,
    output logic [MW-1:0]   o_metric,
    output logic            o_upd
);
    localparam int CW = $clog2(NPIX + 1);
    localparam int SW = $clog2(STEP_MAX + 1);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FLUSH1 = 3'd1;
    localparam logic [2:0] S_FLUSH2 = 3'd2;
    localparam logic [2:0] S_EVAL   = 3'd3;
    localparam logic [2:0] S_APPLY  = 3'd4;

    logic            w_rst, w_rise, w_fall, w_start, w_in_win;
    logic            r_vblank_q, r_armed, r_gate;
    logic [HW-1:0]   r_h0, r_h1, w_h0, w_h1;
    logic [VW-1:0]   r_v0, r_v1, w_v0, w_v1;
    logic [CW-1:0]   r_cnt, w_cnt;
    logic [ACCW-1:0] r_acc;
    logic [ACCW:0]   w_sum;
    logic [2:0]      r_state, w_next;
    logic [MW-1:0]   w_m, w_err, r_m;
    logic            w_dark, w_bright, r_dark, r_bright;
    logic [SW-1:0]   w_step, r_step;
    logic [GW:0]     w_gain_up;
    logic [GW-1:0]   w_gain_inc, w_gain_dec, w_gain_nx;
    logic [EW:0]     w_exp_up;
    logic [EW-1:0]   w_exp_inc, w_exp_dec, w_iexp_cl, w_exp_nx;

    assign w_rst   = !i_init_n || !i_en;
    assign w_rise  = i_vblank && !r_vblank_q;
    assign w_fall  = !i_vblank && r_vblank_q;
    assign w_start = w_rise && r_armed && (r_state == S_IDLE);

    // bounds captured on the falling edge already apply to that first active cycle
    assign w_h0 = w_fall ? i_win_h0 : r_h0;
    assign w_h1 = w_fall ? i_win_h1 : r_h1;
    assign w_v0 = w_fall ? i_win_v0 : r_v0;
    assign w_v1 = w_fall ? i_win_v1 : r_v1;
    assign w_in_win = !i_vblank && i_ah >= w_h0 && i_ah <= w_h1 && i_av >= w_v0 && i_av <= w_v1;
    assign w_sum    = {1'b0, r_acc} + (ACCW + 1)'(r_cnt);

    assign w_m      = r_acc[ACCW-1:SHIFT];
    assign w_dark   = w_m < i_lo_th;
    assign w_bright = !w_dark && w_m > i_hi_th;
    assign w_err    = w_dark ? i_lo_th - w_m : w_m - i_hi_th;
    assign w_step   = !i_mode_prop ? SW'(1) : (w_err > MW'(STEP_MAX)) ? SW'(STEP_MAX) : SW'(w_err);

    assign w_gain_up  = {1'b0, o_gain} + (GW + 1)'(r_step);
    assign w_gain_inc = (w_gain_up > (GW + 1)'(GAIN_MAX)) ? GW'(GAIN_MAX) : w_gain_up[GW-1:0];
    assign w_gain_dec = (o_gain > GW'(r_step)) ? o_gain - GW'(r_step) : '0;
    assign w_exp_up   = {1'b0, o_exp} + (EW + 1)'(r_step);
    assign w_exp_inc  = (w_exp_up > (EW + 1)'(EXP_MAX)) ? EW'(EXP_MAX) : w_exp_up[EW-1:0];
    assign w_exp_dec  = ({1'b0, o_exp} >= (EW + 1)'(EXP_MIN) + (EW + 1)'(r_step)) ? o_exp - EW'(r_step) : EW'(EXP_MIN);
    assign w_iexp_cl  = (i_iexp > EW'(EXP_MAX)) ? EW'(EXP_MAX) : (i_iexp < EW'(EXP_MIN)) ? EW'(EXP_MIN) : i_iexp;

    // popcount of the per-pixel bright flags
    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < NPIX; i++) w_cnt = w_cnt + CW'(i_pix_hit[i]);
    end

    // vblank history is cleared so leaving reset inside blanking finds the controller unarmed
    always_ff @(posedge i_clk) begin
        if (w_rst) begin
            r_vblank_q <= 1'b0;
            r_armed    <= 1'b0;
            r_h0       <= '0;
            r_h1       <= '0;
            r_v0       <= '0;
            r_v1       <= '0;
        end else begin
            r_vblank_q <= i_vblank;
            if (w_fall) begin
                r_armed <= 1'b1;
                r_h0    <= i_win_h0;
                r_h1    <= i_win_h1;
                r_v0    <= i_win_v0;
                r_v1    <= i_win_v1;
            end else if (w_start) begin
                r_armed <= 1'b0;
            end
        end
    end

    // two-stage metering: register gate and count, then saturating accumulate
    always_ff @(posedge i_clk) begin
        if (w_rst) begin
            r_gate <= 1'b0;
            r_cnt  <= '0;
            r_acc  <= '0;
        end else begin
            r_gate <= w_in_win;
            r_cnt  <= w_cnt;
            r_acc  <= w_fall ? '0 : !r_gate ? r_acc : w_sum[ACCW] ? '1 : w_sum[ACCW-1:0];
        end
    end

    // a vblank fall before APPLY abandons the sequence
    always_comb begin
        w_next = (r_state == S_IDLE) ? (w_start ? S_FLUSH1 : S_IDLE) :
                 (r_state == S_APPLY || w_fall) ? S_IDLE : r_state + 3'd1;
    end

    // override loads first, then at most one step on either exposure or gain
    always_comb begin
        w_exp_nx  = i_ext_exp ? w_iexp_cl : o_exp;
        w_gain_nx = i_ext_gain ? i_igain : o_gain;
        if (!(i_ext_exp && i_ext_gain)) begin
            if (r_dark) begin
                if (!i_ext_exp && o_exp < EW'(EXP_MAX)) w_exp_nx = w_exp_inc;
                else if (!i_ext_gain) w_gain_nx = w_gain_inc;
            end else if (r_bright) begin
                if (!i_ext_gain && o_gain != '0) w_gain_nx = w_gain_dec;
                else if (!i_ext_exp) w_exp_nx = w_exp_dec;
            end
        end
    end

    // sequence: flush pipeline, evaluate the metric, publish one update
    always_ff @(posedge i_clk) begin
        if (w_rst) begin
            r_state  <= S_IDLE;
            r_m      <= '0;
            r_dark   <= 1'b0;
            r_bright <= 1'b0;
            r_step   <= '0;
            o_gain   <= '0;
            o_exp    <= EW'(EXP_MIN);
            o_metric <= '0;
            o_upd    <= 1'b0;
        end else begin
            r_state <= w_next;
            o_upd   <= (r_state == S_APPLY);
            if (r_state == S_EVAL) begin
                r_m      <= w_m;
                r_dark   <= w_dark;
                r_bright <= w_bright;
                r_step   <= w_step;
            end
            if (r_state == S_APPLY) begin
                o_metric <= r_m;
                o_gain   <= w_gain_nx;
                o_exp    <= w_exp_nx;
            end
        end
    end
endmodule
